// File: rtl/fp_norm_pkg.sv
// rtl/fp_norm_pkg.sv - shared widths, state encoding and flag indices for the FP normalize/round path
package fp_norm_pkg;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = FRAC_W + 5;

    localparam int FLAG_OVF = 3;
    localparam int FLAG_UNF = 2;
    localparam int FLAG_INX = 1;
    localparam int FLAG_ZER = 0;

    localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLASSIFY = 3'd1,
        ST_NORM     = 3'd2,
        ST_ROUND    = 3'd3,
        ST_POST     = 3'd4,
        ST_DONE     = 3'd5
    } norm_state_e;
endpackage

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - round-to-nearest-even on a 24-bit significand with guard/round/sticky
module fp_round_rne (
    input  logic [23:0] sig_i,
    input  logic        g_i,
    input  logic        r_i,
    input  logic        s_i,
    output logic [23:0] sig_o,
    output logic        carry_o,
    output logic        inexact_o
);
    logic inc;

    // Ties (G=1, R=S=0) round up only when the kept LSB is odd.
    assign inc               = g_i & (r_i | s_i | sig_i[0]);
    assign {carry_o, sig_o}  = {1'b0, sig_i} + {24'd0, inc};
    assign inexact_o         = g_i | r_i | s_i;
endmodule

// File: rtl/fp_norm_round_ctrl.sv
// rtl/fp_norm_round_ctrl.sv - multi-cycle normalize/round sequencer producing a packed single-precision result
module fp_norm_round_ctrl
    import fp_norm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [FRAC_W-1:0] out_frac,
    output logic [3:0]        out_flags
);
    norm_state_e       state_q, state_d;
    logic              sign_q, sign_d;
    logic [EXP_W:0]    exp_q, exp_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic [3:0]        flags_q, flags_d;
    logic              out_valid_q, out_valid_d;
    logic              out_sign_q, out_sign_d;
    logic [EXP_W-1:0]  out_exp_q, out_exp_d;
    logic [FRAC_W-1:0] out_frac_q, out_frac_d;
    logic [3:0]        out_flags_q, out_flags_d;

    logic [23:0]       rnd_sig;
    logic              rnd_carry;
    logic              rnd_inexact;

    fp_round_rne u_round (
        .sig_i     (mant_q[26:3]),
        .g_i       (mant_q[2]),
        .r_i       (mant_q[1]),
        .s_i       (mant_q[0]),
        .sig_o     (rnd_sig),
        .carry_o   (rnd_carry),
        .inexact_o (rnd_inexact)
    );

    assign in_ready  = rst_n & (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_sign  = out_sign_q;
    assign out_exp   = out_exp_q;
    assign out_frac  = out_frac_q;
    assign out_flags = out_flags_q;

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_exp_d   = out_exp_q;
        out_frac_d  = out_frac_q;
        out_flags_d = out_flags_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = {1'b0, in_exp};
                    mant_d  = in_mant;
                    flags_d = 4'd0;
                    state_d = ST_CLASSIFY;
                end
            end
            ST_CLASSIFY: begin
                if (mant_q == '0) begin
                    flags_d[FLAG_ZER] = 1'b1;
                    exp_d   = '0;
                    sign_d  = 1'b0;
                    state_d = ST_DONE;
                end else if (exp_q == '0) begin
                    flags_d[FLAG_UNF] = 1'b1;
                    exp_d   = '0;
                    mant_d  = '0;
                    sign_d  = 1'b0;
                    state_d = ST_DONE;
                end else if (mant_q[27]) begin
                    // The old sticky bit falls off the end, so fold it into the new sticky.
                    mant_d  = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
                    exp_d   = exp_q + 9'd1;
                    state_d = ST_ROUND;
                end else if (mant_q[26]) begin
                    state_d = ST_ROUND;
                end else begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if (exp_q == 9'd1) begin
                    flags_d[FLAG_UNF] = 1'b1;
                    exp_d   = '0;
                    mant_d  = '0;
                    sign_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    mant_d  = mant_q << 1;
                    exp_d   = exp_q - 9'd1;
                    if (mant_q[25]) state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                mant_d = {1'b0, (rnd_carry ? {1'b1, rnd_sig[23:1]} : rnd_sig), 3'b000};
                exp_d  = exp_q + {8'd0, rnd_carry};
                flags_d[FLAG_INX] = rnd_inexact;
                state_d = ST_POST;
            end
            ST_POST: begin
                if (exp_q >= {1'b0, EXP_INF}) begin
                    flags_d[FLAG_OVF] = 1'b1;
                    exp_d  = {1'b0, EXP_INF};
                    mant_d = '0;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                out_sign_d  = sign_q;
                out_exp_d   = exp_q[EXP_W-1:0];
                out_frac_d  = mant_q[25:3];
                out_flags_d = flags_q;
                out_valid_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_frac_q  <= '0;
            out_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_exp_q   <= out_exp_d;
            out_frac_q  <= out_frac_d;
            out_flags_q <= out_flags_d;
        end
    end
endmodule

// File: tb/tb_fp_norm_round_ctrl.sv
// tb/tb_fp_norm_round_ctrl.sv - directed-vector bench for fp_norm_round_ctrl
module tb_fp_norm_round_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [27:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_frac;
    logic [3:0]  out_flags;

    int n_checks = 0;
    int n_errors = 0;

    fp_norm_round_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_frac  (out_frac),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one vector, measure latency, check the packed result, optionally stall, then drain.
    task automatic run_vec(input string tag, input logic s, input logic [7:0] e, input logic [27:0] m,
                           input int lat, input logic want_s, input logic [7:0] want_e,
                           input logic [22:0] want_f, input logic [3:0] want_fl, input int hold);
        int cyc;
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        tick();
        in_valid = 1'b0;
        in_mant  = 28'hFFFFFFF;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({tag, "_lat"},   cyc,       lat);
        chk({tag, "_sign"},  out_sign,  want_s);
        chk({tag, "_exp"},   out_exp,   want_e);
        chk({tag, "_frac"},  out_frac,  want_f);
        chk({tag, "_flags"}, out_flags, want_fl);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_valid"}, out_valid, 1'b1);
            chk({tag, "_hold_rdy"},   in_ready,  1'b0);
            chk({tag, "_hold_flags"}, out_flags, want_fl);
            chk({tag, "_hold_exp"},   out_exp,   want_e);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, out_valid, 1'b0);
        chk({tag, "_drain_rdy"},   in_ready,  1'b1);
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 8'd0;
        in_mant   = 28'd0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready",  in_ready,  1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_exp",   out_exp,   8'h00);
        chk("rst_out_frac",  out_frac,  23'h0);
        chk("rst_out_flags", out_flags, 4'h0);
        chk("rst_out_sign",  out_sign,  1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", in_ready, 1'b1);

        run_vec("t1_exact",   1'b1, 8'h80, 28'h4000000, 4, 1'b1, 8'h80, 23'h0,      4'b0000, 0);
        run_vec("t2_carry",   1'b0, 8'h7F, 28'h8000001, 4, 1'b0, 8'h80, 23'h0,      4'b0010, 0);
        run_vec("t3_norm5",   1'b0, 8'h85, 28'h0200000, 9, 1'b0, 8'h80, 23'h0,      4'b0000, 0);
        run_vec("t4_tie_odd", 1'b0, 8'h80, 28'h7FFFFFC, 4, 1'b0, 8'h81, 23'h0,      4'b0010, 0);
        // Tie with even LSB stays put: frac=0x000001 is odd -> rounds; frac=0x000002 even -> truncates.
        run_vec("t4b_tie_ev", 1'b0, 8'h80, 28'h4000014, 4, 1'b0, 8'h80, 23'h000002, 4'b0010, 0);
        run_vec("t4c_rup",    1'b0, 8'h80, 28'h400000C, 4, 1'b0, 8'h80, 23'h000002, 4'b0010, 0);
        run_vec("t5_ovf",     1'b1, 8'hFE, 28'h8000000, 4, 1'b1, 8'hFF, 23'h0,      4'b1000, 0);
        run_vec("t5_flush",   1'b1, 8'h02, 28'h0400000, 4, 1'b0, 8'h00, 23'h0,      4'b0100, 0);
        run_vec("t5b_exp0",   1'b1, 8'h00, 28'h4000000, 2, 1'b0, 8'h00, 23'h0,      4'b0100, 0);
        run_vec("t6_zero",    1'b1, 8'h90, 28'h0000000, 2, 1'b0, 8'h00, 23'h0,      4'b0001, 10);

        // Reset while the sequencer is shifting must drop the transaction.
        in_valid = 1'b1;
        in_exp   = 8'h85;
        in_mant  = 28'h0200000;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_ready", in_ready,  1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_idle", in_ready, 1'b1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("midrst_no_out", seen, 0);

        run_vec("t7_after",   1'b0, 8'h80, 28'h4000008, 4, 1'b0, 8'h80, 23'h000001, 4'b0000, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
